store_align: RTL and testbench
==============================

STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have no parameters; the design is fixed-width, with a 32-bit data path and a 2-entry buffer.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  store request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_addr  input  32  byte address of the store.
REQ-007 in_data  input  32  register value to store (rt).
REQ-008 in_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 out_valid  output  1  formatted store available.
REQ-010 out_ready  input  1  memory side accepts the store.
REQ-011 out_addr  output  32  word address, {in_addr[31:2],2'b00}.
REQ-012 out_wdata  output  32  lane-replicated write data.
REQ-013 out_be  output  4  byte enables; bit i enables byte i (little-endian lanes).
REQ-014 out_misaligned  output  1  alignment fault flag for the entry at the head.

Function
REQ-015 SHALL be a 2-entry in-order FIFO; push occurs on in_valid&&in_ready; pop occurs on out_valid&&out_ready.
REQ-016 in_ready SHALL equal (count<2)&&!rst; out_valid SHALL equal (count>0).
REQ-017 Latency SHALL be 1 cycle: a request accepted at edge N drives out_* in the cycle after edge N.
REQ-018 At count=1, a simultaneous push and pop SHALL leave count at 1; the newly pushed entry SHALL become the head on the next cycle.
REQ-019 At count=2, in_ready SHALL be 0; a pop SHALL free one slot for the next cycle only, with no same-cycle pass-through.
REQ-020 Formatting SHALL be computed at push time and stored per entry.
REQ-021 Byte store: wdata={4{in_data[7:0]}}; be=4'b0001<<in_addr[1:0].
REQ-022 Halfword store: wdata={2{in_data[15:0]}}; be=in_addr[1]?4'b1100:4'b0011.
REQ-023 Word store: wdata=in_data; be=4'b1111.
REQ-024 Reserved size 11: wdata=in_data; be=4'b0000; misaligned=0. The entry still occupies the FIFO and is still handshaken.
REQ-025 While out_valid=0, out_addr, out_wdata, out_be and out_misaligned SHALL all be 0.
REQ-026 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst=1 at an edge SHALL set count=0 and discard any buffered entries, including an entry mid-handshake.
REQ-028 A push presented in the same cycle as rst SHALL be dropped.
REQ-029 After reset: out_valid=0, all out_* = 0, and in_ready=1 from the first cycle with rst=0.

Configuration
REQ-030 Macro STORE_ALIGN_MISALIGN_EXC_EN controls misalignment detection.
REQ-031 With the macro defined:
- A halfword store with in_addr[0]=1 is flagged misaligned.
- A word store with in_addr[1:0]!=0 is flagged misaligned.
- A flagged entry gets misaligned=1 and be=4'b0000; wdata is formatted as in REQ-021..REQ-023.
REQ-032 Without the macro:
- out_misaligned is constant 0.
- Halfword stores ignore in_addr[0].
- Word stores ignore in_addr[1:0].
- Enables follow REQ-021..REQ-023 unchanged.

Verification
REQ-033 Byte store: addr=0x1003, data=0xAABBCCDD, size=00, out_ready=1 -> next cycle out_addr=0x1000, wdata=0xDDDDDDDD, be=1000, out_valid=1 for one cycle.
REQ-034 Halfword store: addr=0x2002, data=0x12345678, size=01 -> wdata=0x56785678, be=1100, misaligned=0.
REQ-035 Back-pressure: out_ready=0, push three words back-to-back -> first two accepted; in_ready=0 on the third until out_ready=1; outputs emerge in order; head is stable while stalled.
REQ-036 Word store at addr=0x3001:
- With STORE_ALIGN_MISALIGN_EXC_EN: misaligned=1, be=0000.
- Without it: misaligned=0, be=1111, out_addr=0x3000.
REQ-037 Reset mid-operation: count=2 with out_ready=0, assert rst for one cycle -> out_valid=0, all outputs 0, in_ready=1 on the following cycle; the next push emerges one cycle after acceptance.

Source files
------------

// File: rtl/store_align.sv
// store_align: formats CPU stores (byte/halfword/word) into word-addressed,
// lane-replicated write data with byte enables, buffered in a 2-entry FIFO.
// Formatting is computed when a store is pushed and kept with its entry.
// Optional feature: define STORE_ALIGN_MISALIGN_EXC_EN to flag misaligned
// halfword/word stores (enables forced to zero on a flagged entry).
module store_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_be,
  output logic        out_misaligned
);

  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] addr_q  [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_q [2];
  logic [31:0] wdata_d [2];
  logic [3:0]  be_q    [2];
  logic [3:0]  be_d    [2];
  logic        mis_q   [2];
  logic        mis_d   [2];

  logic        push;
  logic        pop;
  logic        wr_idx;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        fmt_mis;

  // Handshakes; a full buffer never accepts, even when the head pops this cycle.
  always_comb begin
    in_ready  = (count_q < 2'd2) && !rst;
    out_valid = (count_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_idx    = head_q ^ count_q[0];
  end

  // Store formatting: lane replication and byte enables from size/address.
  always_comb begin
    fmt_wdata = in_data;
    fmt_be    = 4'b0000;
    fmt_mis   = 1'b0;
    case (in_size)
      2'b00: begin
        fmt_wdata = {4{in_data[7:0]}};
        fmt_be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{in_data[15:0]}};
        fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        fmt_wdata = in_data;
        fmt_be    = 4'b1111;
      end
      default: begin
        fmt_wdata = in_data;
        fmt_be    = 4'b0000;
      end
    endcase
`ifdef STORE_ALIGN_MISALIGN_EXC_EN
    if ((in_size == 2'b01 && in_addr[0]) ||
        (in_size == 2'b10 && in_addr[1:0] != 2'b00)) begin
      fmt_mis = 1'b1;
      fmt_be  = 4'b0000;
    end
`endif
  end

  // FIFO next state: write at tail on push, advance head on pop.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mis_d   = mis_q;
    head_d  = head_q;
    if (push) begin
      addr_d[wr_idx]  = {in_addr[31:2], 2'b00};
      wdata_d[wr_idx] = fmt_wdata;
      be_d[wr_idx]    = fmt_be;
      mis_d[wr_idx]   = fmt_mis;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Head outputs, forced to zero while the buffer is empty.
  always_comb begin
    out_addr       = 32'd0;
    out_wdata      = 32'd0;
    out_be         = 4'b0000;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_addr       = addr_q[head_q];
      out_wdata      = wdata_q[head_q];
      out_be         = be_q[head_q];
      out_misaligned = mis_q[head_q];
    end
  end

  // State registers; reset discards all entries, including one mid-handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      addr_q  <= '{default: '0};
      wdata_q <= '{default: '0};
      be_q    <= '{default: '0};
      mis_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align; honours STORE_ALIGN_MISALIGN_EXC_EN.
module tb_store_align;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_misaligned;

  int total = 0;
  int bad   = 0;

  store_align dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_size        (in_size),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_wdata      (out_wdata),
    .out_be         (out_be),
    .out_misaligned (out_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input logic m);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".addr"},  out_addr, a);
    check({tag, ".wdata"}, out_wdata, d);
    check({tag, ".be"},    {28'd0, out_be}, {28'd0, be});
    check({tag, ".mis"},   {31'd0, out_misaligned}, {31'd0, m});
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    step();
    step();
    // push during reset must be dropped, and in_ready is low under reset
    drive(1'b1, 32'h0000_0040, 32'h1234_5678, 2'b10);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    check_out("post_rst", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // byte store
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_out("byte", 1'b1, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 1'b0);
    step();
    check_out("byte_gone", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0);

    // halfword store, upper half
    drive(1'b1, 32'h0000_2002, 32'h1234_5678, 2'b01);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_out("half", 1'b1, 32'h0000_2000, 32'h5678_5678, 4'b1100, 1'b0);
    step();

    // word store at unaligned address
    drive(1'b1, 32'h0000_3001, 32'h0BAD_F00D, 2'b10);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
`ifdef STORE_ALIGN_MISALIGN_EXC_EN
    check_out("word_unal", 1'b1, 32'h0000_3000, 32'h0BAD_F00D, 4'b0000, 1'b1);
`else
    check_out("word_unal", 1'b1, 32'h0000_3000, 32'h0BAD_F00D, 4'b1111, 1'b0);
`endif
    step();

    // reserved size still handshaken, no enables
    drive(1'b1, 32'h0000_4002, 32'hCAFE_F00D, 2'b11);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_out("rsvd", 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b0000, 1'b0);
    step();
    check("rsvd_gone", {31'd0, out_valid}, 32'd0);

    // back-pressure: three words with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0100, 32'h1111_1111, 2'b10);
    step();
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h0000_0104, 32'h2222_2222, 2'b10);
    step();
    check("bp_rdy2", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h0000_0108, 32'h3333_3333, 2'b10);
    step();
    check("bp_rdy3", {31'd0, in_ready}, 32'd0);
    check_out("bp_stall", 1'b1, 32'h0000_0100, 32'h1111_1111, 4'b1111, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp_no_pass", {31'd0, in_ready}, 32'd0);
    step();
    check_out("bp_w2", 1'b1, 32'h0000_0104, 32'h2222_2222, 4'b1111, 1'b0);
    check("bp_rdy4", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_out("bp_w3", 1'b1, 32'h0000_0108, 32'h3333_3333, 4'b1111, 1'b0);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // simultaneous push/pop at count=1: odd halfword then byte
    drive(1'b1, 32'h0000_5001, 32'h0000_ABCD, 2'b01);
    step();
`ifdef STORE_ALIGN_MISALIGN_EXC_EN
    check_out("half_odd", 1'b1, 32'h0000_5000, 32'hABCD_ABCD, 4'b0000, 1'b1);
`else
    check_out("half_odd", 1'b1, 32'h0000_5000, 32'hABCD_ABCD, 4'b0011, 1'b0);
`endif
    drive(1'b1, 32'h0000_6001, 32'h0000_0077, 2'b00);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_out("byte_b1", 1'b1, 32'h0000_6000, 32'h7777_7777, 4'b0010, 1'b0);
    step();
    check("pp_empty", {31'd0, out_valid}, 32'd0);

    // reset with a full buffer stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_7000, 32'h0101_0101, 2'b10);
    step();
    drive(1'b1, 32'h0000_7004, 32'h0202_0202, 2'b10);
    step();
    check("full_rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    out_ready = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_8000, 32'hDEAD_BEEF, 2'b10);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check_out("after_rst", 1'b1, 32'h0000_8000, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    step();
    check("after_rst_gone", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
